alu_share_arb: RTL and testbench
================================

Name: alu_share_arb

Overview:
- Arbitrates one shared combinational ALU (riscv_pkg alu_op_e ops) between NREQ requesters, e.g. EX-stage integer ops and branch-target/address calculation.
- Each requester has a valid/ready request channel and a 1-entry registered response buffer.
- Grants at most one request per cycle; the result returns one cycle after acceptance.
- The ALU instance sits outside this block; this block drives its inputs and samples its outputs.

Parameters:
- NREQ, 2, number of requesters (legal 2..4).
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  request valid per requester.
- req_ready  out  NREQ  request accepted this cycle (one-hot or zero).
- req_a  in  NREQ x 32  operand A per requester.
- req_b  in  NREQ x 32  operand B per requester.
- req_op  in  NREQ x alu_op_e  operation per requester.
- rsp_valid  out  NREQ  result buffer holds a result.
- rsp_ready  in  NREQ  requester consumes its result.
- rsp_y  out  NREQ x 32  buffered ALU result.
- rsp_zero  out  NREQ  buffered ALU zero flag.
- alu_a  out  32  to shared ALU a.
- alu_b  out  32  to shared ALU b.
- alu_op  out  alu_op_e  to shared ALU op.
- alu_y  in  32  from shared ALU y.
- alu_zero  in  1  from shared ALU zero.
- op_count  out  32  total granted operations; wraps at 2^32.

Behaviour:
- Eligibility: eligible[i] = req_valid[i] && (!rsp_valid[i] || rsp_ready[i]).
  - A requester with a full, undrained buffer cannot be granted.
  - Same-cycle drain plus refill is allowed.
- Grant selection (combinational, one-hot or zero):
  - ARB_MODE=0: scan starts at index (last_grant+1) mod NREQ; the first eligible index wins.
  - ARB_MODE=1: the lowest eligible index wins.
- req_ready = grant.
  - req_ready may depend on req_valid.
  - Requesters must not make req_valid depend on req_ready.
  - A request is accepted when req_valid[i] && req_ready[i].
  - req_a/b/op must be held stable while valid and not ready.
- ALU drive:
  - alu_a/alu_b/alu_op = the granted requester's fields.
  - With no grant: alu_a = 0, alu_b = 0, alu_op = ALU_ADD.
- Result capture at the clock edge:
  - Granted i: rsp_y[i] <= alu_y, rsp_zero[i] <= alu_zero, rsp_valid[i] <= 1.
  - Else if rsp_ready[i]: rsp_valid[i] <= 0; rsp_y and rsp_zero hold.
- Latency: accept in cycle N -> rsp_valid high in cycle N+1. Throughput: 1 op/cycle aggregate.
- last_grant updates only on a grant; it is unchanged in idle cycles.
- op_count increments by 1 per grant.
- Reset (async assert, sync deassert assumed upstream):
  - rsp_valid = 0, rsp_y = 0, rsp_zero = 0, op_count = 0.
  - last_grant = NREQ-1, so requester 0 wins first in RR mode.
  - Reset mid-operation discards all buffered results and any in-flight grant. No output reflects a pre-reset request.
- Boundaries:
  - All requesters valid with empty buffers: RR rotates 0,1,..,NREQ-1,0 with no starvation.
  - Requester blocked by a full buffer is skipped; the pointer still follows actual grants.
  - rsp_ready asserted with rsp_valid=0 is ignored.
  - X on non-granted requester inputs must not propagate to alu_* or rsp_*.

Test Plan:
- Single op: req0 {a=5, b=7, ALU_ADD}, rsp_ready0=1 -> req_ready0=1 in cycle 0; cycle 1 rsp_valid0=1, rsp_y0=12, rsp_zero0=0; op_count=1.
- Contention RR: req0 {5,7,ALU_SUB} and req1 {5,7,ALU_OR} held valid 4 cycles, both rsp_ready=1 -> grants 0,1,0,1. rsp_y0=0xFFFF_FFFE; rsp_y1=0x0000_0007.
- Backpressure: req0 {5,5,ALU_SUB} accepted, rsp_ready0=0, req0 valid again {0xFFFF_FFFF,0,ALU_SLT}:
  - req_ready0=0 while the buffer is full; rsp_y0=0 and rsp_zero0=1 stay held.
  - Raise rsp_ready0 -> same-cycle refill; next cycle rsp_y0=1.
- Fixed priority: ARB_MODE=1, both valid 3 cycles, buffers draining -> req0 granted every cycle, req_ready1=0 throughout.
- Reset mid-op: assert rst_n=0 between a grant and the next edge -> rsp_valid=0, op_count=0 immediately. After release, first contended grant goes to req0.
- Idle: no req_valid -> alu_a=0, alu_b=0, alu_op=ALU_ADD; op_count and last_grant unchanged.

Source files
------------

// File: rtl/alu_share_arb.sv
// alu_share_arb: shares one external combinational ALU between NREQ requesters.
//
// Each requester presents a valid/ready request (operands + op). At most one
// request is granted per cycle. The granted operands drive the external ALU,
// and the ALU result is captured into that requester's 1-entry response
// buffer at the same clock edge. The result is therefore visible one cycle
// after acceptance.
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   req_valid/ready    per-requester request handshake (ready is one-hot or zero)
//   req_a/b/op         per-requester operands and ALU operation
//   rsp_valid/ready    per-requester response buffer handshake
//   rsp_y/rsp_zero     buffered ALU result and zero flag
//   alu_a/b/op         to the shared ALU
//   alu_y/alu_zero     from the shared ALU
//   op_count           total granted operations, wraps at 2^32
//
// Parameters:
//   NREQ      number of requesters (2..4)
//   ARB_MODE  0 = round-robin, 1 = fixed priority (lowest index wins)

package riscv_pkg;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;
endpackage

module alu_share_arb #(
  parameter int NREQ     = 2,
  parameter int ARB_MODE = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NREQ-1:0]             req_valid,
  output logic [NREQ-1:0]             req_ready,
  input  logic [NREQ-1:0][31:0]       req_a,
  input  logic [NREQ-1:0][31:0]       req_b,
  input  riscv_pkg::alu_op_e [NREQ-1:0] req_op,
  output logic [NREQ-1:0]             rsp_valid,
  input  logic [NREQ-1:0]             rsp_ready,
  output logic [NREQ-1:0][31:0]       rsp_y,
  output logic [NREQ-1:0]             rsp_zero,
  output logic [31:0]                 alu_a,
  output logic [31:0]                 alu_b,
  output riscv_pkg::alu_op_e          alu_op,
  input  logic [31:0]                 alu_y,
  input  logic                        alu_zero,
  output logic [31:0]                 op_count
);

  localparam int IDX_W = $clog2(NREQ);

  logic [NREQ-1:0]  eligible;
  logic [NREQ-1:0]  grant;
  logic [IDX_W-1:0] grant_idx;
  logic             any_grant;
  logic [IDX_W-1:0] last_grant;

  // A full buffer can only be refilled if it is being drained this same cycle.
  assign eligible  = req_valid & (~rsp_valid | rsp_ready);
  assign req_ready = grant;

  always_comb begin
    int idx;
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = 0;
    if (ARB_MODE == 1) begin
      // Walk downward so the lowest eligible index is the last one written.
      for (int i = NREQ - 1; i >= 0; i--) begin
        if (eligible[i]) begin
          any_grant = 1'b1;
          grant_idx = i[IDX_W-1:0];
        end
      end
    end else begin
      // Scan starts just after the most recent grant.
      for (int k = 0; k < NREQ; k++) begin
        idx = (int'(last_grant) + 1 + k) % NREQ;
        if (!any_grant && eligible[idx]) begin
          any_grant = 1'b1;
          grant_idx = idx[IDX_W-1:0];
        end
      end
    end
    if (any_grant) grant[grant_idx] = 1'b1;
  end

  // Only the granted requester's fields reach the ALU, so undefined data on
  // idle requesters never leaks out.
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = riscv_pkg::ALU_ADD;
    if (any_grant) begin
      alu_a  = req_a[grant_idx];
      alu_b  = req_b[grant_idx];
      alu_op = req_op[grant_idx];
    end
  end

  // Response buffers: capture on grant, otherwise drain on rsp_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid  <= '0;
      rsp_y      <= '0;
      rsp_zero   <= '0;
      op_count   <= '0;
      last_grant <= IDX_W'(NREQ - 1);
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (grant[i]) begin
          rsp_y[i]     <= alu_y;
          rsp_zero[i]  <= alu_zero;
          rsp_valid[i] <= 1'b1;
        end else if (rsp_ready[i]) begin
          rsp_valid[i] <= 1'b0;
        end
      end
      if (any_grant) begin
        last_grant <= grant_idx;
        op_count   <= op_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arb.sv
module tb_alu_share_arb;
  import riscv_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        req_valid;
  logic [1:0][31:0]  req_a, req_b;
  alu_op_e [1:0]     req_op;
  logic [1:0]        rsp_ready;

  logic [1:0]        rr_req_ready, rr_rsp_valid, rr_rsp_zero;
  logic [1:0][31:0]  rr_rsp_y;
  logic [31:0]       rr_alu_a, rr_alu_b, rr_alu_y, rr_op_count;
  alu_op_e           rr_alu_op;
  logic              rr_alu_zero;

  logic [1:0]        fp_req_ready, fp_rsp_valid, fp_rsp_zero;
  logic [1:0][31:0]  fp_rsp_y;
  logic [31:0]       fp_alu_a, fp_alu_b, fp_alu_y, fp_op_count;
  alu_op_e           fp_alu_op;
  logic              fp_alu_zero;

  always #5 clk = ~clk;

  // Environment model of the external shared ALU.
  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input alu_op_e op);
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_SLL:  return a << b[4:0];
      ALU_SLT:  return {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU: return {31'd0, a < b};
      ALU_XOR:  return a ^ b;
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return $unsigned($signed(a) >>> b[4:0]);
      ALU_OR:   return a | b;
      ALU_AND:  return a & b;
      default:  return 32'd0;
    endcase
  endfunction

  assign rr_alu_y    = alu_f(rr_alu_a, rr_alu_b, rr_alu_op);
  assign rr_alu_zero = (rr_alu_y == 32'd0);
  assign fp_alu_y    = alu_f(fp_alu_a, fp_alu_b, fp_alu_op);
  assign fp_alu_zero = (fp_alu_y == 32'd0);

  alu_share_arb #(.NREQ(2), .ARB_MODE(0)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(rr_req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rr_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_y(rr_rsp_y), .rsp_zero(rr_rsp_zero),
    .alu_a(rr_alu_a), .alu_b(rr_alu_b), .alu_op(rr_alu_op),
    .alu_y(rr_alu_y), .alu_zero(rr_alu_zero),
    .op_count(rr_op_count)
  );

  alu_share_arb #(.NREQ(2), .ARB_MODE(1)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(fp_req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(fp_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_y(fp_rsp_y), .rsp_zero(fp_rsp_zero),
    .alu_a(fp_alu_a), .alu_b(fp_alu_b), .alu_op(fp_alu_op),
    .alu_y(fp_alu_y), .alu_zero(fp_alu_zero),
    .op_count(fp_op_count)
  );

  typedef struct {
    logic [1:0]  valid;
    logic [31:0] a0, b0;
    alu_op_e     op0;
    logic [31:0] a1, b1;
    alu_op_e     op1;
    logic [1:0]  exp_ready;
    logic [31:0] exp_y;
    logic        exp_zero;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] y;
    logic        zero;
  } exp_t;

  vec_t vecs[9];
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    // Round-robin table, all response buffers draining every cycle.
    vecs[0] = '{2'b11, 32'd5, 32'd7, ALU_SUB, 32'd5, 32'd7, ALU_OR, 2'b01, 32'hFFFF_FFFE, 1'b0};
    vecs[1] = '{2'b11, 32'd5, 32'd7, ALU_SUB, 32'd5, 32'd7, ALU_OR, 2'b10, 32'h0000_0007, 1'b0};
    vecs[2] = '{2'b11, 32'd5, 32'd7, ALU_SUB, 32'd5, 32'd7, ALU_OR, 2'b01, 32'hFFFF_FFFE, 1'b0};
    vecs[3] = '{2'b11, 32'd5, 32'd7, ALU_SUB, 32'd5, 32'd7, ALU_OR, 2'b10, 32'h0000_0007, 1'b0};
    vecs[4] = '{2'b01, 32'd5, 32'd7, ALU_ADD, 32'd0, 32'd0, ALU_ADD, 2'b01, 32'd12, 1'b0};
    vecs[5] = '{2'b10, 32'd0, 32'd0, ALU_ADD, 32'd3, 32'd3, ALU_SUB, 2'b10, 32'd0, 1'b1};
    vecs[6] = '{2'b00, 32'hDEAD_BEEF, 32'h1234_5678, ALU_SRA, 32'hCAFE_F00D, 32'h5555_AAAA, ALU_XOR,
                2'b00, 32'd0, 1'b0};
    vecs[7] = '{2'b11, 32'd8, 32'd2, ALU_SLL, 32'hF0, 32'h0F, ALU_AND, 2'b01, 32'd32, 1'b0};
    vecs[8] = '{2'b11, 32'd8, 32'd2, ALU_SLL, 32'hF0, 32'h0F, ALU_AND, 2'b10, 32'd0, 1'b1};

    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_op    = {ALU_ADD, ALU_ADD};
    rsp_ready = 2'b11;
    @(posedge clk); @(posedge clk); #1;
    chk("reset rsp_valid", 64'(rr_rsp_valid), 64'd0);
    chk("reset op_count", 64'(rr_op_count), 64'd0);
    chk("reset rsp_y0", 64'(rr_rsp_y[0]), 64'd0);
    chk("reset rsp_zero", 64'(rr_rsp_zero), 64'd0);
    rst_n = 1'b1;

    // Table-driven round-robin sequence with scoreboard.
    @(posedge clk); #1;
    for (int v = 0; v < 9; v++) begin
      req_valid = vecs[v].valid;
      req_a[0] = vecs[v].a0; req_b[0] = vecs[v].b0; req_op[0] = vecs[v].op0;
      req_a[1] = vecs[v].a1; req_b[1] = vecs[v].b1; req_op[1] = vecs[v].op1;
      #1;
      chk($sformatf("v%0d req_ready", v), 64'(rr_req_ready), 64'(vecs[v].exp_ready));
      if (vecs[v].exp_ready == 2'b00) begin
        chk($sformatf("v%0d idle alu_a", v), 64'(rr_alu_a), 64'd0);
        chk($sformatf("v%0d idle alu_b", v), 64'(rr_alu_b), 64'd0);
        chk($sformatf("v%0d idle alu_op", v), 64'(rr_alu_op), 64'(ALU_ADD));
      end else begin
        e.idx  = vecs[v].exp_ready[1] ? 1 : 0;
        e.y    = vecs[v].exp_y;
        e.zero = vecs[v].exp_zero;
        sb.push_back(e);
      end
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        if (rr_rsp_valid[i]) begin
          if (sb.size() == 0) begin
            chk($sformatf("v%0d spurious rsp%0d", v, i), 64'(rr_rsp_valid[i]), 64'd0);
          end else begin
            e = sb.pop_front();
            chk($sformatf("v%0d rsp idx", v), 64'(i), 64'(e.idx));
            chk($sformatf("v%0d rsp_y", v), 64'(rr_rsp_y[i]), 64'(e.y));
            chk($sformatf("v%0d rsp_zero", v), 64'(rr_rsp_zero[i]), 64'(e.zero));
          end
        end
      end
    end
    chk("sb drained", 64'(sb.size()), 64'd0);
    chk("op_count after table", 64'(rr_op_count), 64'd8);

    // Backpressure: hold a full buffer, then drain and refill in one cycle.
    rsp_ready = 2'b00;
    req_valid = 2'b01;
    req_a[0] = 32'd5; req_b[0] = 32'd5; req_op[0] = ALU_SUB;
    #1;
    chk("bp first accept", 64'(rr_req_ready), 64'b01);
    @(posedge clk); #1;
    req_a[0] = 32'hFFFF_FFFF; req_b[0] = 32'd0; req_op[0] = ALU_SLT;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk($sformatf("bp blocked ready c%0d", c), 64'(rr_req_ready), 64'b00);
      chk($sformatf("bp held y0 c%0d", c), 64'(rr_rsp_y[0]), 64'd0);
      chk($sformatf("bp held zero0 c%0d", c), 64'(rr_rsp_zero[0]), 64'd1);
      chk($sformatf("bp held valid0 c%0d", c), 64'(rr_rsp_valid[0]), 64'd1);
      @(posedge clk); #1;
    end
    rsp_ready = 2'b01;
    #1;
    chk("bp refill ready", 64'(rr_req_ready), 64'b01);
    @(posedge clk); #1;
    chk("bp refill y0", 64'(rr_rsp_y[0]), 64'd1);
    chk("bp refill zero0", 64'(rr_rsp_zero[0]), 64'd0);
    chk("bp op_count", 64'(rr_op_count), 64'd10);
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    @(posedge clk); #1;
    chk("bp drained", 64'(rr_rsp_valid), 64'd0);

    // Fixed priority: req0 wins every cycle while both are valid.
    req_valid = 2'b11;
    req_a[0] = 32'd9; req_b[0] = 32'd4; req_op[0] = ALU_XOR;
    req_a[1] = 32'd1; req_b[1] = 32'd1; req_op[1] = ALU_ADD;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("fp ready c%0d", c), 64'(fp_req_ready), 64'b01);
      @(posedge clk); #1;
      chk($sformatf("fp rsp_valid c%0d", c), 64'(fp_rsp_valid), 64'b01);
      chk($sformatf("fp rsp_y0 c%0d", c), 64'(fp_rsp_y[0]), 64'd13);
    end

    // Reset between a grant and the next edge.
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst rsp_valid", 64'(rr_rsp_valid), 64'd0);
    chk("rst op_count", 64'(rr_op_count), 64'd0);
    chk("rst rsp_y", {rr_rsp_y[1], rr_rsp_y[0]}, 64'd0);
    @(posedge clk); #1;
    chk("rst held rsp_valid", 64'(rr_rsp_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post-rst first grant", 64'(rr_req_ready), 64'b01);
    @(posedge clk); #1;
    chk("post-rst rsp_valid", 64'(rr_rsp_valid), 64'b01);
    chk("post-rst rsp_y0", 64'(rr_rsp_y[0]), 64'd13);
    chk("post-rst op_count", 64'(rr_op_count), 64'd1);
    req_valid = 2'b00;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
